// File: rtl/ddr_axi_rd_master.sv
// AXI4 INCR burst read master: splits a (start address, beat count) command into
// 4 KB-safe bursts, keeps up to MAX_OUTSTANDING in flight, streams R beats out.
module ddr_axi_rd_master #(
  parameter int C_M_AXI_ID_WIDTH   = 4,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int AXI_ID             = 0,
  parameter int MAX_BURST_LEN      = 16,
  parameter int MAX_OUTSTANDING    = 4,
  parameter int BEAT_CNT_WIDTH     = 16
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [BEAT_CNT_WIDTH-1:0]       cmd_beats,
  output logic [C_M_AXI_ID_WIDTH-1:0]     m_axi_arid,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]                      m_axi_arlen,
  output logic [2:0]                      m_axi_arsize,
  output logic [1:0]                      m_axi_arburst,
  output logic                            m_axi_arlock,
  output logic [3:0]                      m_axi_arcache,
  output logic [2:0]                      m_axi_arprot,
  output logic [3:0]                      m_axi_arqos,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  input  logic [C_M_AXI_ID_WIDTH-1:0]     m_axi_rid,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rlast,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   dout_data,
  output logic                            dout_valid,
  input  logic                            dout_ready,
  output logic                            dout_last,
  output logic                            done,
  output logic                            busy,
  output logic                            err
);

  localparam int AW   = C_M_AXI_ADDR_WIDTH;
  localparam int BW   = BEAT_CNT_WIDTH;
  localparam int SIZE = $clog2(C_M_AXI_DATA_WIDTH / 8);
  localparam int LW   = (BW > 13) ? BW + 1 : 14;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [BW-1:0] iss_rem_q, iss_rem_d;
  logic [BW-1:0] rx_rem_q, rx_rem_d;
  logic [3:0]    outs_cnt_q, outs_cnt_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic          ready_q;

  logic [LW-1:0] room_beats, blen;
  logic          ar_hs, r_hs, rlast_hs;
  logic          unused_inputs;

  assign unused_inputs = ^{m_axi_rid, m_axi_rresp[0]};

  // Beats left before the next 4 KB page boundary.
  assign room_beats = LW'((13'h1000 - {1'b0, addr_q[11:0]}) >> SIZE);

  always_comb begin
    blen = LW'(iss_rem_q);
    if (blen > LW'(MAX_BURST_LEN)) blen = LW'(MAX_BURST_LEN);
    if (blen > room_beats)         blen = room_beats;
  end

  assign m_axi_arid    = C_M_AXI_ID_WIDTH'(AXI_ID);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = 8'(blen - LW'(1));
  assign m_axi_arsize  = 3'(SIZE);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arqos   = 4'b0000;
  assign m_axi_arvalid = (state_q == ISSUE) && (outs_cnt_q < 4'(MAX_OUTSTANDING));

  assign m_axi_rready = dout_ready;
  assign dout_valid   = m_axi_rvalid;
  assign dout_data    = m_axi_rdata;
  assign dout_last    = m_axi_rvalid && (rx_rem_q == BW'(1));

  assign cmd_ready = ready_q && (state_q == IDLE);
  assign done      = done_q;
  assign busy      = busy_q;
  assign err       = err_q;

  assign ar_hs    = m_axi_arvalid && m_axi_arready;
  assign r_hs     = m_axi_rvalid && dout_ready && (state_q != IDLE);
  assign rlast_hs = r_hs && m_axi_rlast;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    iss_rem_d  = iss_rem_q;
    rx_rem_d   = rx_rem_q;
    outs_cnt_d = outs_cnt_q;
    done_d     = 1'b0;
    busy_d     = busy_q;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d    = {cmd_addr[AW-1:SIZE], {SIZE{1'b0}}};
          iss_rem_d = cmd_beats;
          rx_rem_d  = cmd_beats;
          err_d     = 1'b0;
          if (cmd_beats == '0) begin
            done_d = 1'b1;
            busy_d = 1'b0;
          end else begin
            busy_d  = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (ar_hs) begin
          addr_d    = addr_q + (AW'(blen) << SIZE);
          iss_rem_d = iss_rem_q - BW'(blen);
          if (iss_rem_q == BW'(blen)) state_d = DRAIN;
        end
      end
      default: ;
    endcase

    // The final beat closes the command regardless of which active state we are in.
    if (r_hs) begin
      rx_rem_d = rx_rem_q - BW'(1);
      if (m_axi_rresp[1]) err_d = 1'b1;
      if (rx_rem_q == BW'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
    end

    case ({ar_hs, rlast_hs})
      2'b10:   outs_cnt_d = outs_cnt_q + 4'd1;
      2'b01:   outs_cnt_d = outs_cnt_q - 4'd1;
      default: outs_cnt_d = outs_cnt_q;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      iss_rem_q  <= '0;
      rx_rem_q   <= '0;
      outs_cnt_q <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      iss_rem_q  <= iss_rem_d;
      rx_rem_q   <= rx_rem_d;
      outs_cnt_q <= outs_cnt_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      ready_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr_axi_rd_master.sv
// Randomised bench for ddr_axi_rd_master: a behavioural AXI slave plus a reference
// model that derives bursts, beat data, done/busy/err timing from the command alone.
module tb_ddr_axi_rd_master;

  localparam int DW = 512;
  localparam int AW = 32;
  localparam int IW = 4;
  localparam int BL = 16;
  localparam int MO = 4;
  localparam int BW = 16;
  localparam int BYTES = DW / 8;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [AW-1:0]   cmd_addr = '0;
  logic [BW-1:0]   cmd_beats = '0;
  logic [IW-1:0]   m_axi_arid;
  logic [AW-1:0]   m_axi_araddr;
  logic [7:0]      m_axi_arlen;
  logic [2:0]      m_axi_arsize;
  logic [1:0]      m_axi_arburst;
  logic            m_axi_arlock;
  logic [3:0]      m_axi_arcache;
  logic [2:0]      m_axi_arprot;
  logic [3:0]      m_axi_arqos;
  logic            m_axi_arvalid;
  logic            m_axi_arready = 1'b0;
  logic [IW-1:0]   m_axi_rid = '0;
  logic [DW-1:0]   m_axi_rdata = '0;
  logic [1:0]      m_axi_rresp = '0;
  logic            m_axi_rlast = 1'b0;
  logic            m_axi_rvalid = 1'b0;
  logic            m_axi_rready;
  logic [DW-1:0]   dout_data;
  logic            dout_valid;
  logic            dout_ready = 1'b0;
  logic            dout_last;
  logic            done;
  logic            busy;
  logic            err;

  always #5 aclk = ~aclk;

  ddr_axi_rd_master #(
    .C_M_AXI_ID_WIDTH(IW), .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW),
    .AXI_ID(0), .MAX_BURST_LEN(BL), .MAX_OUTSTANDING(MO), .BEAT_CNT_WIDTH(BW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .done(done), .busy(busy), .err(err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state (values the DUT should show after the next clock edge).
  bit          exp_init, exp_busy, exp_err, exp_done;
  int          tb_outs;
  int unsigned exp_ar_addr[$];
  int          exp_ar_len[$];
  int unsigned exp_base;
  int          exp_beats, beat_idx, ar_count;

  // Slave-side bookkeeping of bursts the DUT actually issued.
  int unsigned sl_addr[$];
  int          sl_len[$];
  int          r_idx, r_total;

  // Stimulus knobs.
  int ar_pct = 100, r_pct = 100, dr_mode = 1, err_beat = -1;
  bit r_hold = 0, tog = 0;
  bit cmd_pending = 0;
  logic [AW-1:0] cmd_a = '0;
  logic [BW-1:0] cmd_b = '0;

  task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic logic [DW-1:0] pat(input logic [31:0] a);
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = a + 32'(i) * 32'h0101_0101;
    return v;
  endfunction

  // Expected burst list from plain page/length arithmetic.
  task automatic buildModel(input logic [AW-1:0] addr, input int beats);
    int unsigned a;
    int rem, room, len;
    a = addr & ~32'(BYTES - 1);
    exp_base = a;
    exp_beats = beats;
    beat_idx = 0;
    r_total = 0;
    rem = beats;
    while (rem > 0) begin
      room = (4096 - int'(a % 4096)) / BYTES;
      len = rem;
      if (len > BL) len = BL;
      if (len > room) len = room;
      exp_ar_addr.push_back(a);
      exp_ar_len.push_back(len - 1);
      a += 32'(len * BYTES);
      rem -= len;
    end
  endtask

  task automatic tick();
    bit acc, arh, rh;
    @(negedge aclk);
    cmd_valid = cmd_pending;
    cmd_addr  = cmd_a;
    cmd_beats = cmd_b;
    m_axi_arready = ($urandom_range(99) < ar_pct);
    case (dr_mode)
      0: dout_ready = 1'($urandom_range(1));
      1: dout_ready = 1'b1;
      default: begin tog = ~tog; dout_ready = tog; end
    endcase
    if (sl_addr.size() > 0 && !r_hold && $urandom_range(99) < r_pct) begin
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = pat(sl_addr[0] + 32'(r_idx * BYTES));
      m_axi_rlast  = (r_idx == sl_len[0]);
      m_axi_rresp  = (r_total == err_beat) ? 2'b10 : 2'b00;
    end else begin
      m_axi_rvalid = 1'b0;
      m_axi_rdata  = '0;
      m_axi_rlast  = 1'b0;
      m_axi_rresp  = 2'b00;
    end
    #1;
    checkOutput("cmd_ready", cmd_ready, exp_init && !exp_busy);
    checkOutput("busy", busy, exp_busy);
    checkOutput("done", done, exp_done);
    checkOutput("err", err, exp_err);
    checkOutput("arvalid", m_axi_arvalid, (exp_ar_addr.size() > 0) && (tb_outs < MO));
    checkOutput("rready", m_axi_rready, dout_ready);
    checkOutput("dout_valid", dout_valid, m_axi_rvalid);
    checkOutput("dout_last", dout_last, m_axi_rvalid && (beat_idx == exp_beats - 1));
    if (m_axi_arvalid && exp_ar_addr.size() > 0) begin
      checkOutput("araddr", m_axi_araddr, exp_ar_addr[0]);
      checkOutput("arlen", m_axi_arlen, exp_ar_len[0]);
      checkOutput("ar_fixed",
        {m_axi_arid, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos},
        {4'd0, 3'd6, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0});
    end

    acc = cmd_valid && cmd_ready;
    arh = m_axi_arvalid && m_axi_arready;
    rh  = m_axi_rvalid && dout_ready && exp_busy;
    exp_done = 1'b0;
    if (acc) begin
      cmd_pending = 1'b0;
      buildModel(cmd_addr, int'(cmd_beats));
      exp_err = 1'b0;
      if (cmd_beats == '0) exp_done = 1'b1;
      else exp_busy = 1'b1;
    end
    if (arh) begin
      ar_count++;
      if (exp_ar_addr.size() == 0) checkOutput("ar_extra", 1'b1, 1'b0);
      else begin
        void'(exp_ar_addr.pop_front());
        void'(exp_ar_len.pop_front());
      end
      sl_addr.push_back(m_axi_araddr);
      sl_len.push_back(int'(m_axi_arlen));
      tb_outs++;
    end
    if (rh) begin
      checkOutput("dout_data", dout_data, pat(exp_base + 32'(beat_idx * BYTES)));
      if (m_axi_rresp[1]) exp_err = 1'b1;
      beat_idx++;
      r_idx++;
      r_total++;
      if (m_axi_rlast) begin
        void'(sl_addr.pop_front());
        void'(sl_len.pop_front());
        r_idx = 0;
        tb_outs--;
      end
      if (beat_idx == exp_beats) begin
        exp_busy = 1'b0;
        exp_done = 1'b1;
      end
    end
  endtask

  task automatic startCmd(input logic [AW-1:0] a, input int beats);
    cmd_pending = 1'b1;
    cmd_a = a;
    cmd_b = BW'(beats);
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (cmd_pending || exp_busy || exp_done) begin
      if (n == budget) begin
        checkOutput("timeout", 1'b0, 1'b1);
        break;
      end
      tick();
      n++;
    end
  endtask

  task automatic applyStimulus(input logic [AW-1:0] a, input int beats);
    startCmd(a, beats);
    waitDone(6000);
  endtask

  task automatic doReset();
    @(negedge aclk);
    aresetn = 1'b0;
    cmd_pending = 1'b0; cmd_valid = 1'b0; m_axi_arready = 1'b0;
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00; dout_ready = 1'b0;
    exp_init = 0; exp_busy = 0; exp_err = 0; exp_done = 0; tb_outs = 0;
    exp_ar_addr.delete(); exp_ar_len.delete(); sl_addr.delete(); sl_len.delete();
    exp_beats = 0; beat_idx = 0; r_idx = 0; r_total = 0;
    #1;
    checkOutput("rst_outputs", {cmd_ready, m_axi_arvalid, busy, done, err, dout_last}, 6'b0);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    checkOutput("rst_release_ready", cmd_ready, 1'b0);
    exp_init = 1'b1;
  endtask

  initial begin
    doReset();

    // Single command, everything always ready.
    ar_pct = 100; r_pct = 100; dr_mode = 1; err_beat = -1; ar_count = 0;
    applyStimulus(32'h0000_1000, 40);
    checkOutput("single_ar_count", 32'(ar_count), 32'd3);

    // 4 KB page crossing with an unaligned request address.
    ar_count = 0;
    applyStimulus(32'h0000_0FC7, 3);
    checkOutput("cross_ar_count", 32'(ar_count), 32'd2);

    // Outstanding limit: slave withholds data until the master stalls.
    ar_count = 0; r_hold = 1;
    startCmd(32'h0002_0000, 96);
    for (int i = 0; i < 30; i++) tick();
    checkOutput("outs_limit", 32'(ar_count), 32'd4);
    r_hold = 0;
    waitDone(6000);
    checkOutput("outs_total", 32'(ar_count), 32'd6);

    // Backpressure toggling every cycle.
    dr_mode = 2; r_pct = 80;
    applyStimulus(32'h0003_0F00, 50);

    // Error on beat 5, then zero-length command clears it.
    dr_mode = 1; err_beat = 4;
    applyStimulus(32'h0000_4000, 20);
    for (int i = 0; i < 3; i++) tick();
    err_beat = -1; ar_count = 0;
    applyStimulus(32'h0000_8000, 0);
    checkOutput("zero_ar_count", 32'(ar_count), 32'd0);

    // Reset while issuing, with err already set.
    r_pct = 50; ar_pct = 50; err_beat = 1;
    startCmd(32'h0001_0000, 200);
    for (int i = 0; i < 25; i++) tick();
    doReset();
    err_beat = -1;
    applyStimulus(32'h0001_0040, 33);

    // Randomised commands and handshake behaviour.
    for (int k = 0; k < 14; k++) begin
      ar_pct   = int'($urandom_range(30, 100));
      r_pct    = int'($urandom_range(30, 100));
      dr_mode  = int'($urandom_range(2));
      err_beat = ($urandom_range(3) == 0) ? int'($urandom_range(20)) : -1;
      applyStimulus($urandom & 32'h000F_FFFF, ($urandom_range(7) == 0) ? 0 : int'($urandom_range(1, 90)));
      for (int i = 0; i < int'($urandom_range(3)); i++) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
